// File: rtl/ph_pwm_pkg.sv
// Shared constants for the multi-phase PWM block: FSM encoding and period defaults.
// Optional dead-time insertion elsewhere in this slice is enabled by PH_PWM_DEADTIME_EN.
package ph_pwm_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEF_PERIOD_C = 1000;
  // Periods below this are clamped so the counter always has a wrap cycle.
  localparam int MIN_PERIOD   = 2;

endpackage

// File: rtl/multi_ph_pwm_if.sv
// Control/output bundle for multi_ph_pwm; deadtime/pwm_n exist only with PH_PWM_DEADTIME_EN.
// load is a one-cycle strobe with no ready: values on *_in are captured on every cycle load=1.
interface multi_ph_pwm_if #(
  parameter int NCH  = 3,
  parameter int CW   = 16,
  parameter int DT_W = 8
) ();

  logic                enable;
  logic                load;
  logic [CW-1:0]       period_in;
  logic [NCH*CW-1:0]   duty_in;
  logic [NCH*CW-1:0]   phase_in;
  logic                pend;
  logic                sync;
  logic [NCH-1:0]      pwm;
  logic [0:0]          dbg_state;
  logic [CW-1:0]       dbg_cnt;
`ifdef PH_PWM_DEADTIME_EN
  logic [DT_W-1:0]     deadtime;
  logic [NCH-1:0]      pwm_n;

  modport master (
    output enable, load, period_in, duty_in, phase_in, deadtime,
    input  pend, sync, pwm, pwm_n, dbg_state, dbg_cnt
  );
  modport slave (
    input  enable, load, period_in, duty_in, phase_in, deadtime,
    output pend, sync, pwm, pwm_n, dbg_state, dbg_cnt
  );
`else
  modport master (
    output enable, load, period_in, duty_in, phase_in,
    input  pend, sync, pwm, dbg_state, dbg_cnt
  );
  modport slave (
    input  enable, load, period_in, duty_in, phase_in,
    output pend, sync, pwm, dbg_state, dbg_cnt
  );
`endif

  if (NCH < 1 || NCH > 16 || CW < 2 || DT_W < 1) begin : g_bad_param
    $error("multi_ph_pwm_if: parameter out of range");
  end

endinterface

// File: rtl/ph_pwm_deadtime.sv
// Per-channel dead-time inserter: delays rising edges of either side by deadtime cycles.
// Only compiled and instantiated when PH_PWM_DEADTIME_EN is defined.
`ifdef PH_PWM_DEADTIME_EN
module ph_pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            pwm_h,
  output logic            pwm_l
);

  logic            lvl;
  logic [DT_W-1:0] age;
  logic [DT_W-1:0] age_nx;
  logic            settled;

  // age counts cycles the raw level has been stable; it restarts at 0 on every change.
  always_comb begin
    age_nx = '0;
    if (raw == lvl) age_nx = (&age) ? age : age + DT_W'(1);
  end

  assign settled = (age_nx >= deadtime);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      lvl   <= 1'b0;
      age   <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      lvl   <= raw;
      age   <= age_nx;
      pwm_h <= raw && settled;
      pwm_l <= !raw && settled;
    end
  end

endmodule
`endif

// File: rtl/multi_ph_pwm.sv
// N-channel phase-shifted PWM: master counter, IDLE/RUN FSM, shadow/active banks, comparators.
// Define PH_PWM_DEADTIME_EN for complementary outputs with dead-time insertion.
module multi_ph_pwm
  import ph_pwm_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int CW         = 16,
  parameter int DEF_PERIOD = DEF_PERIOD_C,
  parameter int DT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  multi_ph_pwm_if.slave  bus
);

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic           pend;
  logic           sync_q;
  logic [CW-1:0]  act_period, sh_period, per_eff;
  logic [CW-1:0]  act_duty  [NCH];
  logic [CW-1:0]  act_phase [NCH];
  logic [CW-1:0]  sh_duty   [NCH];
  logic [CW-1:0]  sh_phase  [NCH];
  logic [NCH-1:0] raw;
  logic           run_ok, wrap, at_bound, take_in, take_sh;

  assign per_eff  = (act_period < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : act_period;
  assign run_ok   = (state == ST_RUN) && bus.enable;
  assign wrap     = (cnt >= per_eff - CW'(1));
  // Active registers may change only while idle or on the wrap cycle of a running period.
  assign at_bound = (state == ST_IDLE) || (bus.enable && wrap);
  assign take_in  = bus.load && at_bound;
  assign take_sh  = pend && at_bound;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      sync_q     <= 1'b0;
      act_period <= CW'(DEF_PERIOD);
      sh_period  <= CW'(DEF_PERIOD);
      for (int i = 0; i < NCH; i++) begin
        act_duty[i]  <= '0;
        act_phase[i] <= '0;
        sh_duty[i]   <= '0;
        sh_phase[i]  <= '0;
      end
    end else begin
      sync_q <= run_ok && (cnt == '0);
      if (bus.load) begin
        sh_period <= bus.period_in;
        for (int i = 0; i < NCH; i++) begin
          sh_duty[i]  <= bus.duty_in[i*CW +: CW];
          sh_phase[i] <= bus.phase_in[i*CW +: CW];
        end
      end
      // A strobe on the boundary cycle is newer than anything in the shadow, so it wins.
      if (take_in) begin
        act_period <= bus.period_in;
        for (int i = 0; i < NCH; i++) begin
          act_duty[i]  <= bus.duty_in[i*CW +: CW];
          act_phase[i] <= bus.phase_in[i*CW +: CW];
        end
      end else if (take_sh) begin
        act_period <= sh_period;
        for (int i = 0; i < NCH; i++) begin
          act_duty[i]  <= sh_duty[i];
          act_phase[i] <= sh_phase[i];
        end
      end
      pend <= at_bound ? 1'b0 : (pend | bus.load);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] ph;
    logic [CW:0]   sum;
    logic [CW:0]   cpos;
    assign ph      = (act_phase[i] >= per_eff) ? '0 : act_phase[i];
    assign sum     = {1'b0, cnt} + {1'b0, ph};
    assign cpos    = (sum >= {1'b0, per_eff}) ? sum - {1'b0, per_eff} : sum;
    assign raw[i]  = (cpos < {1'b0, act_duty[i]});
  end

`ifdef PH_PWM_DEADTIME_EN
  logic [NCH-1:0] hi, lo;
  for (genvar i = 0; i < NCH; i++) begin : g_dt
    ph_pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk      (clk),
      .reset    (reset),
      .run      (run_ok),
      .raw      (raw[i]),
      .deadtime (bus.deadtime),
      .pwm_h    (hi[i]),
      .pwm_l    (lo[i])
    );
  end
  assign bus.pwm   = hi;
  assign bus.pwm_n = lo;
`else
  logic [NCH-1:0] pwm_q;
  always_ff @(posedge clk) begin
    if (reset) pwm_q <= '0;
    else       pwm_q <= run_ok ? raw : '0;
  end
  assign bus.pwm = pwm_q;
`endif

  assign bus.pend      = pend;
  assign bus.sync      = sync_q;
  assign bus.dbg_state = state;
  assign bus.dbg_cnt   = cnt;

  if (NCH < 1 || NCH > 16 || CW < 2 || DT_W < 1) begin : g_bad_param
    $error("multi_ph_pwm: parameter out of range");
  end

endmodule
